// File: rtl/lcd_text_pkg.sv
// Shared defaults, character codes and FSM states
// for the LCD text frame buffer.
package lcd_text_pkg;

  localparam int DEF_COLS = 16;
  localparam int DEF_LINES = 2;
  localparam logic [7:0] DEF_BLANK = 8'h00;

  localparam int LINE_W = 1;
  localparam int COL_W = 4;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_EIGHT = 8'h38;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_A = 8'h41;
  localparam logic [7:0] CH_U = 8'h55;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    SCAN
  } state_t;

  function automatic int lin_addr(
    input int line,
    input int col,
    input int cols
  );
    return line * cols + col;
  endfunction

endpackage

// File: rtl/lcd_char_ram.sv
// Character store: synchronous write,
// combinational read.
module lcd_char_ram #(
  parameter int DEPTH = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lcd_text_buffer.sv
// Two-line character frame buffer that streams
// one frame per request to the LCD data stage.
module lcd_text_buffer
  import lcd_text_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int LINES = DEF_LINES,
  parameter logic [7:0] BLANK = DEF_BLANK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [LINE_W-1:0] wr_line,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [7:0]        wr_char,
  input  logic              clr_req,
  input  logic              frame_start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_char,
  output logic [LINE_W-1:0] out_line,
  output logic [COL_W-1:0]  out_col,
  output logic              out_last,
  output logic              busy
);

  localparam int DEPTH = LINES * COLS;
  localparam int AW = $clog2(DEPTH);

  state_t r_state;
  state_t w_next;

  logic [AW-1:0]     r_clr_addr;
  logic [LINE_W-1:0] r_nline;
  logic [COL_W-1:0]  r_ncol;

  logic              r_out_valid;
  logic [7:0]        r_out_char;
  logic [LINE_W-1:0] r_out_line;
  logic [COL_W-1:0]  r_out_col;
  logic              r_out_last;

  logic          w_load;
  logic          w_acc;
  logic          w_clr_done;
  logic          w_ptr_last;
  logic          w_wr_in;
  logic          w_wr_ok;
  logic          w_we;
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_waddr;
  logic [7:0]    w_wdata;
  logic [AW-1:0] w_rd_addr;
  logic [7:0]    w_rd_data;

  assign wr_ready = (r_state != CLEAR);
  assign busy = (r_state != IDLE);

  assign w_acc = r_out_valid & out_ready;
  assign w_clr_done = (r_clr_addr == AW'(DEPTH - 1));
  assign w_ptr_last = (r_nline == LINE_W'(LINES - 1))
                   && (r_ncol == COL_W'(COLS - 1));

  assign w_wr_in = (int'(wr_col) < COLS)
                && (int'(wr_line) < LINES);
  // clr_req swallows a same-cycle write
  assign w_wr_ok = wr_valid & wr_ready
                 & w_wr_in & ~clr_req;
  assign w_wr_addr = AW'(lin_addr(int'(wr_line),
                     int'(wr_col), COLS));
  assign w_rd_addr = AW'(lin_addr(int'(r_nline),
                     int'(r_ncol), COLS));

  assign w_we = (r_state == CLEAR) | w_wr_ok;
  assign w_waddr = (r_state == CLEAR) ? r_clr_addr
                                      : w_wr_addr;
  assign w_wdata = (r_state == CLEAR) ? BLANK
                                      : wr_char;

  lcd_char_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(w_wdata),
    .i_raddr(w_rd_addr),
    .o_rdata(w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= CLEAR;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    unique case (r_state)
      CLEAR: begin
        if (!clr_req && w_clr_done) w_next = IDLE;
      end
      IDLE: begin
        if (clr_req) begin
          w_next = CLEAR;
        end else if (frame_start) begin
          w_next = SCAN;
          w_load = 1'b1;
        end
      end
      SCAN: begin
        if (clr_req) begin
          w_next = CLEAR;
        end else if (w_acc) begin
          if (r_out_last) w_next = IDLE;
          else w_load = 1'b1;
        end
      end
      default: w_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_addr  <= '0;
      r_nline     <= '0;
      r_ncol      <= '0;
      r_out_valid <= 1'b0;
      r_out_char  <= '0;
      r_out_line  <= '0;
      r_out_col   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (clr_req) r_clr_addr <= '0;
      else if (r_state == CLEAR)
        r_clr_addr <= r_clr_addr + AW'(1);

      // pointer rests at (0,0) outside a scan
      if (w_next != SCAN) begin
        r_nline <= '0;
        r_ncol  <= '0;
      end else if (w_load) begin
        if (r_ncol == COL_W'(COLS - 1)) begin
          r_ncol  <= '0;
          r_nline <= r_nline + LINE_W'(1);
        end else begin
          r_ncol <= r_ncol + COL_W'(1);
        end
      end

      if (clr_req) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end else if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_char  <= w_rd_data;
        r_out_line  <= r_nline;
        r_out_col   <= r_ncol;
        r_out_last  <= w_ptr_last;
      end else if (w_acc) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_char  = r_out_char;
  assign out_line  = r_out_line;
  assign out_col   = r_out_col;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Directed bench for lcd_text_buffer: default
// 16x2 instance plus a 12-column instance.
module tb_lcd_text_buffer;
  import lcd_text_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       wr_valid, wr_ready, wr_line;
  logic [3:0] wr_col;
  logic [7:0] wr_char;
  logic       clr_req, frame_start;
  logic       out_valid, out_ready, out_line;
  logic [7:0] out_char;
  logic [3:0] out_col;
  logic       out_last, busy;

  logic       wv_b, wr_ready_b, wl_b;
  logic [3:0] wc_b;
  logic [7:0] wd_b;
  logic       clr_b, fs_b;
  logic       ov_b, ord_b, ol_b;
  logic [7:0] oc_b;
  logic [3:0] ocol_b;
  logic       olast_b, busy_b;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_mem [32];

  lcd_text_buffer u_dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_line    (wr_line),
    .wr_col     (wr_col),
    .wr_char    (wr_char),
    .clr_req    (clr_req),
    .frame_start(frame_start),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_char   (out_char),
    .out_line   (out_line),
    .out_col    (out_col),
    .out_last   (out_last),
    .busy       (busy)
  );

  lcd_text_buffer #(.COLS(12)) u_dut12 (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wv_b),
    .wr_ready   (wr_ready_b),
    .wr_line    (wl_b),
    .wr_col     (wc_b),
    .wr_char    (wd_b),
    .clr_req    (clr_b),
    .frame_start(fs_b),
    .out_valid  (ov_b),
    .out_ready  (ord_b),
    .out_char   (oc_b),
    .out_line   (ol_b),
    .out_col    (ocol_b),
    .out_last   (olast_b),
    .busy       (busy_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic wr_a(input logic l,
                      input logic [3:0] c,
                      input logic [7:0] ch);
    wr_valid = 1'b1;
    wr_line = l;
    wr_col = c;
    wr_char = ch;
    chk("wr_ready", 32'(wr_ready), 1);
    @(negedge clk);
    wr_valid = 1'b0;
    exp_mem[int'(l) * 16 + int'(c)] = ch;
  endtask

  task automatic scan_a(input bit rnd);
    int k;
    int cyc;
    int gaps;
    k = 0;
    cyc = 0;
    gaps = 0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("start_valid", 32'(out_valid), 1);
    while (k < 32 && cyc < 400) begin
      if (out_valid) begin
        chk($sformatf("b%0d_char", k),
            32'(out_char), 32'(exp_mem[k]));
        chk($sformatf("b%0d_line", k),
            32'(out_line), k / 16);
        chk($sformatf("b%0d_col", k),
            32'(out_col), k % 16);
        chk($sformatf("b%0d_last", k),
            32'(out_last), 32'(k == 31));
        out_ready = rnd ? 1'($urandom_range(0, 1))
                        : 1'b1;
        if (out_ready) k++;
      end else begin
        gaps++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    chk("scan_beats", k, 32);
    chk("scan_gaps", gaps, 0);
    chk("end_valid", 32'(out_valid), 0);
    chk("end_busy", 32'(busy), 0);
  endtask

  initial begin
    int nbad;
    int k;
    int cyc;
    int gaps;
    wr_valid = 0; wr_line = 0; wr_col = 0;
    wr_char = 0; clr_req = 0; frame_start = 0;
    out_ready = 1;
    wv_b = 0; wl_b = 0; wc_b = 0; wd_b = 0;
    clr_b = 0; fs_b = 0; ord_b = 1;
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_char", 32'(out_char), 0);
    chk("rst_line", 32'(out_line), 0);
    chk("rst_col", 32'(out_col), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_busy", 32'(busy), 1);
    rst = 1'b0;

    nbad = 0;
    repeat (31) begin
      @(negedge clk);
      if (!(busy === 1'b1 && wr_ready === 1'b0
            && out_valid === 1'b0)) nbad++;
    end
    chk("clear_hold", nbad, 0);
    @(negedge clk);
    chk("clear_done_busy", 32'(busy), 0);
    chk("clear_done_ready", 32'(wr_ready), 1);

    scan_a(1'b0);

    wr_a(1'b0, 4'd3, CH_COLON);
    wr_a(1'b1, 4'd9, CH_EIGHT);
    scan_a(1'b0);

    scan_a(1'b1);

    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_pre_valid", 32'(out_valid), 1);
    chk("abort_pre_col", 32'(out_col), 10);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_last", 32'(out_last), 0);
    nbad = 0;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      frame_start = (i == 5);
      if (!(busy === 1'b1 && wr_ready === 1'b0
            && out_valid === 1'b0)) nbad++;
    end
    chk("abort_clear_hold", nbad, 0);
    @(negedge clk);
    chk("abort_done_busy", 32'(busy), 0);
    chk("abort_done_ready", 32'(wr_ready), 1);
    @(negedge clk);
    chk("fs_not_queued", 32'(out_valid), 0);
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h00;
    scan_a(1'b0);

    wv_b = 1'b1; wl_b = 1'b0;
    wc_b = 4'hF; wd_b = CH_U;
    chk("b_wr_ready", 32'(wr_ready_b), 1);
    @(negedge clk);
    wl_b = 1'b1; wc_b = 4'd11; wd_b = CH_A;
    @(negedge clk);
    wv_b = 1'b0;
    fs_b = 1'b1;
    @(negedge clk);
    fs_b = 1'b0;
    k = 0; cyc = 0; gaps = 0;
    while (k < 24 && cyc < 200) begin
      fs_b = (k == 5);
      if (ov_b) begin
        chk($sformatf("c%0d_char", k), 32'(oc_b),
            (k == 23) ? 32'(CH_A) : 0);
        chk($sformatf("c%0d_line", k),
            32'(ol_b), k / 12);
        chk($sformatf("c%0d_col", k),
            32'(ocol_b), k % 12);
        chk($sformatf("c%0d_last", k),
            32'(olast_b), 32'(k == 23));
        k++;
      end else begin
        gaps++;
      end
      @(negedge clk);
      cyc++;
    end
    fs_b = 1'b0;
    chk("b_beats", k, 24);
    chk("b_gaps", gaps, 0);
    nbad = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (ov_b !== 1'b0) nbad++;
    end
    chk("b_single_frame", nbad, 0);
    chk("b_idle", 32'(busy_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_text_buffer.md
# lcd_text_buffer

Character frame buffer that sits directly upstream of the LCD data stage. It holds two lines of 16 character codes written by the application. On request, it streams the whole frame one character per beat into the LCD driver, which owns lcd_en, lcd_rs and lcd_db. It replaces hard-wired text tables with writable storage, so names, IDs and messages can change at run time.

## Interface
Parameters:
- COLS, 16, characters per line
- LINES, 2, display lines
- BLANK, 8'h00, character code the display stage renders as a space

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accept; handshake completes when wr_valid & wr_ready
- wr_line  in  1  target line (log2 LINES)
- wr_col  in  4  target column (log2 COLS)
- wr_char  in  8  character code
- clr_req  in  1  single-cycle pulse: blank the whole buffer
- frame_start  in  1  single-cycle pulse from the display stage: stream one frame
- out_valid  out  1  beat valid
- out_ready  in  1  display stage accepts beat
- out_char  out  8  character code
- out_line  out  1  line of current beat
- out_col  out  4  column of current beat
- out_last  out  1  high on final beat of the frame
- busy  out  1  high in CLEAR or SCAN

## Operation
- Storage is LINES*COLS entries of 8 bits, addressed as line*COLS+col.
- FSM states:
  - CLEAR: writes BLANK to one address per cycle, from 0 up to LINES*COLS-1, then goes to IDLE. Entered on reset release and on clr_req.
  - IDLE: waits. frame_start moves to SCAN with the pointer at (0,0).
  - SCAN: presents beats in order line 0 col 0..COLS-1, then line 1. After the beat with out_last=1 is accepted, returns to IDLE.
- wr_ready is 1 in IDLE and SCAN and 0 in CLEAR. Writes to any address are allowed during SCAN.
- Boundary rules:
  - A write with wr_col >= COLS completes its handshake and is dropped.
  - frame_start in SCAN or CLEAR is ignored. It is not queued.
  - clr_req in IDLE or SCAN aborts any scan and enters CLEAR. It has priority over frame_start and over a same-cycle write; that write completes its handshake and is discarded.
  - clr_req in CLEAR restarts the clear from address 0.

## Timing
- During rst and in the first cycle after it, outputs are: out_valid=0, out_char=0, out_line=0, out_col=0, out_last=0, wr_ready=0, busy=1.
- CLEAR lasts exactly LINES*COLS cycles (32 by default). wr_ready rises in the cycle after the last blank write.
- Scan start: frame_start sampled high in IDLE gives out_valid=1 on the next cycle.
- Beat contents:
  - out_char is the storage content captured when the beat is loaded.
  - A write to that address in the loading cycle is not visible in that beat. A write to a later address before its beat is loaded is visible.
- Handshake: out_valid, out_char, out_line, out_col and out_last are held stable until out_ready is high. The next beat appears the cycle after acceptance, so the peak rate is one beat per cycle.
- After the last beat is accepted, out_valid is 0 and busy is 0 on the next cycle.
- Abort by clr_req: out_valid is 0 on the next cycle, and no partial out_last is ever issued.
- Write latency: data written in cycle N is readable by a beat loaded in cycle N+1.

## Structure
- Package lcd_text_pkg holds:
  - the COLS, LINES and BLANK defaults
  - the character codes used by callers
  - the FSM state enum {CLEAR, IDLE, SCAN}
- Sub-module lcd_char_ram: LINES*COLS x 8 register array with one synchronous write port and one combinational read port. The FSM, pointer and output register stay in lcd_text_buffer.

## Test plan
- Reset release: busy=1 and wr_ready=0 for 32 cycles. Then frame_start returns 32 beats, all 8'h00, the last with out_last=1 at (1,15).
- Write 8'h3A to (0,3) and 8'h38 to (1,9), then frame_start with out_ready always 1: beats 3 and 25 carry those codes, all others 8'h00, back-to-back one per cycle.
- Drive out_ready with a random 50% pattern: beat order and values are unchanged, and outputs stay stable while stalled.
- clr_req at beat 10 of a scan: out_valid=0 next cycle, busy stays 1 for 32 cycles, and a new scan returns all 8'h00.
- Write with wr_col=4'hF on COLS=12, and frame_start during SCAN: the write is dropped, and only one frame is emitted.
